// File: rtl/comp_dispatch.sv
// comp_dispatch: round-robin dispatcher; write 1 cycle after accept, start 1 cycle later; at most 1 accept per 3 cycles.
// in_ready only while parked on a free thread; sticky err for bad done reports built only with COMP_DISPATCH_ERR_CHECK_EN.
`ifndef MSB
`define MSB(x) ($clog2((x)+1)-1)
`endif
`ifndef COMP_DATA1_MSB
`define COMP_DATA1_MSB 7
`endif
`ifndef COMP_DATA2_MSB
`define COMP_DATA2_MSB 15
`endif

module comp_dispatch #(
  parameter int N_THREADS     = 16,
  parameter int N_THREADS_MSB = `MSB(N_THREADS-1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [`COMP_DATA1_MSB:0] in_data1,
  input  logic [`COMP_DATA2_MSB:0] in_data2,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [N_THREADS_MSB:0]   wr_thread_num,
  output logic [`COMP_DATA1_MSB:0] wr_data1,
  output logic [`COMP_DATA2_MSB:0] wr_data2,
  output logic                     start,
  output logic [N_THREADS_MSB:0]   start_thread_num,
  input  logic                     done_en,
  input  logic [N_THREADS_MSB:0]   done_thread_num,
  output logic [N_THREADS_MSB+1:0] busy_count,
  output logic                     idle,
  output logic                     err
);
  localparam int TW = N_THREADS_MSB + 1;
  localparam int CW = N_THREADS_MSB + 2;
  localparam int NB = 1 << TW;
  localparam logic [TW-1:0] LAST = TW'(N_THREADS - 1);

  typedef enum logic [1:0] {S_SCAN, S_ACCEPT, S_START} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [TW-1:0]           r_ptr;
  logic [TW-1:0]           w_ptr_inc;
  // Padded to a power of two so any thread number indexes safely; bits >= N_THREADS stay 0.
  logic [NB-1:0]           r_busy;
  logic [NB-1:0]           w_set_mask;
  logic [NB-1:0]           w_clr_mask;
  logic [CW-1:0]           r_busy_count;
  logic                    w_in_ready;
  logic                    w_in_start;
  logic                    w_scan_adv;
  logic                    w_accept;
  logic                    w_clr;
  logic                    r_wr_en;
  logic [TW-1:0]           r_wr_thread_num;
  logic [`COMP_DATA1_MSB:0] r_wr_data1;
  logic [`COMP_DATA2_MSB:0] r_wr_data2;
  logic                    r_start;
  logic [TW-1:0]           r_start_thread_num;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_SCAN;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_SCAN:   if (!r_busy[r_ptr]) w_next_state = S_ACCEPT;
      S_ACCEPT: if (in_valid) w_next_state = S_START;
      S_START:  w_next_state = S_SCAN;
      default:  w_next_state = S_SCAN;
    endcase
  end

  always_comb begin
    w_in_ready = 1'b0;
    w_in_start = 1'b0;
    w_scan_adv = 1'b0;
    case (r_state)
      S_SCAN:   w_scan_adv = r_busy[r_ptr];
      S_ACCEPT: w_in_ready = 1'b1;
      S_START:  w_in_start = 1'b1;
      default:  w_in_ready = 1'b0;
    endcase
  end

  assign w_accept  = w_in_ready & in_valid;
  assign w_ptr_inc = (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
  // A release for a thread that is not busy (or out of range) is a no-op.
  assign w_clr      = done_en & (done_thread_num <= LAST) & r_busy[done_thread_num];
  assign w_set_mask = w_accept ? (NB'(1) << r_ptr) : '0;
  assign w_clr_mask = w_clr ? (NB'(1) << done_thread_num) : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr        <= '0;
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      if (w_scan_adv || w_in_start) r_ptr <= w_ptr_inc;
      r_busy <= (r_busy | w_set_mask) & ~w_clr_mask;
      case ({w_accept, w_clr})
        2'b10:   r_busy_count <= r_busy_count + CW'(1);
        2'b01:   r_busy_count <= r_busy_count - CW'(1);
        default: r_busy_count <= r_busy_count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_en            <= 1'b0;
      r_wr_thread_num    <= '0;
      r_wr_data1         <= '0;
      r_wr_data2         <= '0;
      r_start            <= 1'b0;
      r_start_thread_num <= '0;
    end else begin
      r_wr_en <= w_accept;
      r_start <= w_in_start;
      if (w_accept) begin
        r_wr_thread_num <= r_ptr;
        r_wr_data1      <= in_data1;
        r_wr_data2      <= in_data2;
      end
      if (w_in_start) r_start_thread_num <= r_ptr;
    end
  end

`ifdef COMP_DISPATCH_ERR_CHECK_EN
  logic r_err;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_err <= 1'b0;
    else if (done_en && ((done_thread_num > LAST) || !r_busy[done_thread_num])) r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign in_ready         = w_in_ready;
  assign wr_en            = r_wr_en;
  assign wr_thread_num    = r_wr_thread_num;
  assign wr_data1         = r_wr_data1;
  assign wr_data2         = r_wr_data2;
  assign start            = r_start;
  assign start_thread_num = r_start_thread_num;
  assign busy_count       = r_busy_count;
  assign idle             = (r_busy_count == '0);

endmodule

// File: tb/tb_comp_dispatch.sv
// Bench for comp_dispatch with 4 threads: directed scenarios plus random traffic against a round-robin model.
`ifndef COMP_DATA1_MSB
`define COMP_DATA1_MSB 7
`endif
`ifndef COMP_DATA2_MSB
`define COMP_DATA2_MSB 15
`endif

module tb_comp_dispatch;
  localparam int N  = 4;
  localparam int TW = 2;
  localparam int D1 = `COMP_DATA1_MSB + 1;
  localparam int D2 = `COMP_DATA2_MSB + 1;
`ifdef COMP_DISPATCH_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [D1-1:0] in_data1;
  logic [D2-1:0] in_data2;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [TW-1:0] wr_thread_num;
  logic [D1-1:0] wr_data1;
  logic [D2-1:0] wr_data2;
  logic          start;
  logic [TW-1:0] start_thread_num;
  logic          done_en;
  logic [TW-1:0] done_thread_num;
  logic [TW:0]   busy_count;
  logic          idle;
  logic          err;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  comp_dispatch #(.N_THREADS(N), .N_THREADS_MSB(TW-1)) dut (
    .CLK(CLK), .RST(RST),
    .in_data1(in_data1), .in_data2(in_data2), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_thread_num(wr_thread_num), .wr_data1(wr_data1), .wr_data2(wr_data2),
    .start(start), .start_thread_num(start_thread_num),
    .done_en(done_en), .done_thread_num(done_thread_num),
    .busy_count(busy_count), .idle(idle), .err(err)
  );

  task automatic do_reset;
    @(negedge CLK);
    RST = 1'b1; in_valid = 1'b0; done_en = 1'b0;
    in_data1 = '0; in_data2 = '0; done_thread_num = '0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Offers one computation (entered at a negedge), optionally with a done in the handshake cycle.
  task automatic send(input logic [D1-1:0] d1, input logic [D2-1:0] d2,
                      input bit with_done, input logic [TW-1:0] dnum,
                      output bit ok, output logic wen, output logic [TW-1:0] wthr,
                      output logic [D1-1:0] wd1, output logic [D2-1:0] wd2,
                      output logic [TW:0] cnt, output logic sok, output logic [TW-1:0] sthr);
    int k;
    in_data1 = d1; in_data2 = d2; in_valid = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 64) begin
      @(negedge CLK);
      k++;
    end
    ok = (in_ready === 1'b1);
    if (ok && with_done) begin
      done_en = 1'b1; done_thread_num = dnum;
    end
    @(negedge CLK);
    in_valid = 1'b0; done_en = 1'b0;
    wen = wr_en; wthr = wr_thread_num; wd1 = wr_data1; wd2 = wr_data2; cnt = busy_count;
    @(negedge CLK);
    sok = start; sthr = start_thread_num;
  endtask

  task automatic test_first;
    do_reset;
    in_valid = 1'b1; in_data1 = 8'h11; in_data2 = 16'h2233;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL first_ready_c1: got %b want 0", in_ready); end
    @(negedge CLK);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL first_ready_c2: got %b want 1", in_ready); end
    @(negedge CLK);
    in_valid = 1'b0;
    total++;
    if (wr_en !== 1'b1 || wr_thread_num !== 2'd0 || wr_data1 !== 8'h11 || start !== 1'b0) begin
      bad++; $display("FAIL first_write: wr_en=%b thr=%0d d1=%h start=%b want 1 0 11 0", wr_en, wr_thread_num, wr_data1, start);
    end
    @(negedge CLK);
    total++;
    if (start !== 1'b1 || start_thread_num !== 2'd0 || wr_en !== 1'b0) begin
      bad++; $display("FAIL first_start: start=%b thr=%0d wr_en=%b want 1 0 0", start, start_thread_num, wr_en);
    end
    total++;
    if (busy_count !== 3'd1 || idle !== 1'b0) begin
      bad++; $display("FAIL first_count: cnt=%0d idle=%b want 1 0", busy_count, idle);
    end
  endtask

  task automatic test_reset;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || wr_en !== 1'b0 || start !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: rdy=%b wr=%b st=%b err=%b want 0 0 0 0", in_ready, wr_en, start, err);
    end
    total++;
    if (wr_thread_num !== '0 || wr_data1 !== '0 || wr_data2 !== '0 || start_thread_num !== '0) begin
      bad++; $display("FAIL reset_data: thr=%0d d1=%h d2=%h sthr=%0d want 0", wr_thread_num, wr_data1, wr_data2, start_thread_num);
    end
    total++;
    if (busy_count !== '0 || idle !== 1'b1) begin
      bad++; $display("FAIL reset_count: cnt=%0d idle=%b want 0 1", busy_count, idle);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit ok; logic wen, sok; logic [TW-1:0] wthr, sthr; logic [D1-1:0] d1, wd1; logic [D2-1:0] d2, wd2;
    logic [TW:0] cnt; bit rdy_seen;
    do_reset;
    for (int i = 0; i < N; i++) begin
      d1 = D1'($urandom); d2 = D2'($urandom);
      send(d1, d2, 1'b0, '0, ok, wen, wthr, wd1, wd2, cnt, sok, sthr);
      total++;
      if (!ok || wen !== 1'b1 || wthr !== TW'(i) || wd1 !== d1 || wd2 !== d2) begin
        bad++; $display("FAIL b2b_write%0d: ok=%0d wen=%b thr=%0d d1=%h d2=%h want 1 1 %0d %h %h", i, ok, wen, wthr, wd1, wd2, i, d1, d2);
      end
      total++;
      if (sok !== 1'b1 || sthr !== TW'(i)) begin
        bad++; $display("FAIL b2b_start%0d: start=%b thr=%0d want 1 %0d", i, sok, sthr, i);
      end
    end
    total++;
    if (busy_count !== 3'd4 || idle !== 1'b0) begin
      bad++; $display("FAIL b2b_full: cnt=%0d idle=%b want 4 0", busy_count, idle);
    end
    in_valid = 1'b1;
    rdy_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (in_ready !== 1'b0 || wr_en !== 1'b0) rdy_seen = 1'b1;
    end
    total++; if (rdy_seen) begin bad++; $display("FAIL b2b_full_ready: got ready/write while full, want none"); end
    done_en = 1'b1; done_thread_num = 2'd2;
    @(negedge CLK);
    done_en = 1'b0;
    d1 = D1'($urandom); d2 = D2'($urandom);
    send(d1, d2, 1'b0, '0, ok, wen, wthr, wd1, wd2, cnt, sok, sthr);
    total++;
    if (!ok || wen !== 1'b1 || wthr !== 2'd2 || wd1 !== d1 || cnt !== 3'd4) begin
      bad++; $display("FAIL b2b_refill: ok=%0d wen=%b thr=%0d d1=%h cnt=%0d want 1 1 2 %h 4", ok, wen, wthr, wd1, cnt, d1);
    end
  endtask

  task automatic test_same_cycle;
    bit ok; logic wen, sok; logic [TW-1:0] wthr, sthr; logic [D1-1:0] wd1; logic [D2-1:0] wd2;
    logic [TW:0] cnt;
    do_reset;
    for (int i = 0; i < 3; i++) send(D1'(i), D2'(i), 1'b0, '0, ok, wen, wthr, wd1, wd2, cnt, sok, sthr);
    total++;
    if (busy_count !== 3'd3) begin bad++; $display("FAIL same_pre: cnt=%0d want 3", busy_count); end
    send(8'hA3, 16'hBEEF, 1'b1, 2'd1, ok, wen, wthr, wd1, wd2, cnt, sok, sthr);
    total++;
    if (!ok || wen !== 1'b1 || wthr !== 2'd3 || cnt !== 3'd3) begin
      bad++; $display("FAIL same_cycle: ok=%0d wen=%b thr=%0d cnt=%0d want 1 1 3 3", ok, wen, wthr, cnt);
    end
    send(8'h5C, 16'h1234, 1'b0, '0, ok, wen, wthr, wd1, wd2, cnt, sok, sthr);
    total++;
    if (!ok || wthr !== 2'd1 || sthr !== 2'd1 || cnt !== 3'd4) begin
      bad++; $display("FAIL same_reuse: ok=%0d thr=%0d sthr=%0d cnt=%0d want 1 1 1 4", ok, wthr, sthr, cnt);
    end
  endtask

  task automatic test_err;
    do_reset;
    done_en = 1'b1; done_thread_num = 2'd0;
    @(negedge CLK);
    done_en = 1'b0;
    total++;
    if (err !== EXP_ERR || busy_count !== '0) begin
      bad++; $display("FAIL err_set: err=%b cnt=%0d want %b 0", err, busy_count, EXP_ERR);
    end
    repeat (3) @(negedge CLK);
    total++;
    if (err !== EXP_ERR || busy_count !== '0 || idle !== 1'b1) begin
      bad++; $display("FAIL err_sticky: err=%b cnt=%0d idle=%b want %b 0 1", err, busy_count, idle, EXP_ERR);
    end
  endtask

  task automatic test_rst_in_start;
    int k; bit pulsed;
    do_reset;
    in_valid = 1'b1; in_data1 = 8'h77;
    k = 0;
    while (in_ready !== 1'b1 && k < 16) begin @(negedge CLK); k++; end
    @(negedge CLK);
    in_valid = 1'b0;
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL rst_start_pre: wr_en=%b want 1", wr_en); end
    RST = 1'b1;
    #1;
    total++;
    if (wr_en !== 1'b0 || start !== 1'b0 || busy_count !== '0 || idle !== 1'b1) begin
      bad++; $display("FAIL rst_start_now: wr=%b st=%b cnt=%0d idle=%b want 0 0 0 1", wr_en, start, busy_count, idle);
    end
    @(negedge CLK);
    RST = 1'b0;
    pulsed = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (wr_en !== 1'b0 || start !== 1'b0 || busy_count !== '0) pulsed = 1'b1;
    end
    total++; if (pulsed) begin bad++; $display("FAIL rst_start_after: got wr/start pulse or count, want none"); end
  endtask

  // Model: a new computation goes to the first free thread at or after the one following the last start.
  task automatic test_random;
    bit mbusy [N];
    int mcnt, nxt, park, q;
    bit parked, found, pend_wr, pend_st, hs, v, dn;
    logic [TW-1:0] pw_thr, ps_thr;
    logic [D1-1:0] pw_d1, d1;
    logic [D2-1:0] pw_d2, d2;
    do_reset;
    for (int i = 0; i < N; i++) mbusy[i] = 1'b0;
    mcnt = 0; nxt = 0; park = 0; parked = 0; pend_wr = 0; pend_st = 0;
    pw_thr = '0; ps_thr = '0; pw_d1 = '0; pw_d2 = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      total++;
      if (wr_en !== pend_wr || (pend_wr && (wr_thread_num !== pw_thr || wr_data1 !== pw_d1 || wr_data2 !== pw_d2))) begin
        bad++; $display("FAIL rnd_write@%0d: wr=%b thr=%0d d1=%h d2=%h want %b %0d %h %h", cyc, wr_en, wr_thread_num, wr_data1, wr_data2, pend_wr, pw_thr, pw_d1, pw_d2);
      end
      total++;
      if (start !== pend_st || (pend_st && start_thread_num !== ps_thr)) begin
        bad++; $display("FAIL rnd_start@%0d: start=%b thr=%0d want %b %0d", cyc, start, start_thread_num, pend_st, ps_thr);
      end
      total++;
      if (busy_count !== (TW+1)'(mcnt) || idle !== (mcnt == 0) || err !== 1'b0) begin
        bad++; $display("FAIL rnd_count@%0d: cnt=%0d idle=%b err=%b want %0d %b 0", cyc, busy_count, idle, err, mcnt, mcnt == 0);
      end
      total++;
      if (in_ready === 1'b1 && mcnt == N) begin
        bad++; $display("FAIL rnd_full_ready@%0d: ready=1 want 0", cyc);
      end
      if (in_ready === 1'b1 && !parked) begin
        parked = 1; found = 0;
        for (int j = 0; j < N; j++) begin
          if (!found && !mbusy[(nxt + j) % N]) begin park = (nxt + j) % N; found = 1; end
        end
      end
      pend_st = pend_wr; ps_thr = pw_thr;
      v  = ($urandom_range(0, 9) < 6);
      d1 = D1'($urandom); d2 = D2'($urandom);
      hs = v && (in_ready === 1'b1);
      dn = 0; q = 0;
      if ((in_ready === 1'b1 || mcnt == N) && mcnt > 0 && $urandom_range(0, 2) == 0) begin
        do q = $urandom_range(0, N-1); while (!mbusy[q]);
        dn = 1;
      end
      in_valid = v; in_data1 = d1; in_data2 = d2;
      done_en = dn; done_thread_num = TW'(q);
      pend_wr = hs;
      if (hs) begin
        pw_thr = TW'(park); pw_d1 = d1; pw_d2 = d2;
        mbusy[park] = 1; nxt = (park + 1) % N; parked = 0;
      end
      if (dn) mbusy[q] = 0;
      mcnt = 0;
      for (int j = 0; j < N; j++) mcnt += int'(mbusy[j]);
      @(negedge CLK);
    end
    in_valid = 1'b0; done_en = 1'b0;
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; done_en = 1'b0;
    in_data1 = '0; in_data2 = '0; done_thread_num = '0;
    test_first;
    test_reset;
    test_back_to_back;
    test_same_cycle;
    test_err;
    test_rst_in_start;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
